// File: rtl/ant_switch_allocator_pkg.sv
// Shared types and constants for the ant router switch allocator.
// Packet kinds (normal, forward ant, backward ant) are routed identically.
package ant_switch_allocator_pkg;

  localparam int N       = 5;
  localparam int M       = 5;
  localparam int X_NODES = 4;
  localparam int Y_NODES = 4;

  // Output port indices; request bit j selects output j
  localparam int WEST  = 0;
  localparam int SOUTH = 1;
  localparam int EAST  = 2;
  localparam int NORTH = 3;
  localparam int LOCAL = 4;

  typedef enum logic [1:0] {
    PKT_NORMAL  = 2'd0,
    PKT_FWD_ANT = 2'd1,
    PKT_BWD_ANT = 2'd2
  } pkt_kind_e;

  typedef struct packed {
    pkt_kind_e   kind;
    logic [2:0]  dst_x;
    logic [2:0]  dst_y;
    logic [23:0] payload;
  } packet_t;

endpackage

// File: rtl/ant_switch_allocator_if.sv
// Input/output bundle of the switch allocator.
// The slave side is the allocator; the master side is the upstream and downstream environment.
interface ant_switch_allocator_if
  import ant_switch_allocator_pkg::*;
#(
  parameter int N_PORTS = N,
  parameter int M_PORTS = M
) ();

  packet_t [0:N_PORTS-1]              i_data;
  logic    [0:N_PORTS-1]              i_data_val;
  logic    [0:N_PORTS-1][M_PORTS-1:0] i_output_req;
  logic    [0:M_PORTS-1]              i_en;
  packet_t [0:M_PORTS-1]              o_data;
  logic    [0:M_PORTS-1]              o_data_val;
  logic    [0:N_PORTS-1]              o_grant;
  logic                               o_error;

  modport slave (
    input  i_data, i_data_val, i_output_req, i_en,
    output o_data, o_data_val, o_grant, o_error
  );

  modport master (
    output i_data, i_data_val, i_output_req, i_en,
    input  o_data, o_data_val, o_grant, o_error
  );

endinterface

// File: rtl/ant_switch_allocator_rr_arbiter.sv
// Round-robin arbiter for one output port: the search starts at ptr and wraps,
// and ptr moves to one past the winner only when a grant is issued.
module ant_rr_arbiter #(
  parameter int N_PORTS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic               en,
  output logic [N_PORTS-1:0] grant
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          hit;

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    hit   = 1'b0;
    if (en) begin
      for (int k = 0; k < N_PORTS; k++) begin
        sum = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(N_PORTS)) sum = sum - (PW+1)'(N_PORTS);
        idx = sum[PW-1:0];
        if (!hit && req[idx]) begin
          hit        = 1'b1;
          win        = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (win == PW'(N_PORTS-1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/ant_switch_allocator.sv
// Switch allocator: decodes one-hot output requests, arbitrates each output round-robin,
// and registers the winning packet onto the output with a valid/ready handshake.
module ant_switch_allocator
  import ant_switch_allocator_pkg::*;
#(
  parameter int N_PORTS = N,
  parameter int M_PORTS = M
) (
  input  logic                  clk,
  input  logic                  reset,
  ant_switch_allocator_if.slave bus
);

  logic [M_PORTS-1:0] dec      [N_PORTS];
  logic [N_PORTS-1:0] arb_req  [M_PORTS];
  logic [N_PORTS-1:0] arb_gnt  [M_PORTS];
  packet_t            sel_data [M_PORTS];
  logic [0:M_PORTS-1] free;
  logic [0:M_PORTS-1] won;
  logic [0:N_PORTS-1] gnt_any;
  logic               malformed;

  // Lowest set bit wins, so an input can never be granted more than one output
  always_comb begin
    malformed = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      dec[i] = '0;
      if (bus.i_data_val[i]) begin
        dec[i] = bus.i_output_req[i] & (~bus.i_output_req[i] + M_PORTS'(1));
        if (bus.i_output_req[i] == '0 ||
            (bus.i_output_req[i] & (bus.i_output_req[i] - M_PORTS'(1))) != '0)
          malformed = 1'b1;
      end
    end
  end

  always_comb begin
    free    = '0;
    arb_req = '{default: '0};
    for (int j = 0; j < M_PORTS; j++) begin
      free[j] = !bus.o_data_val[j] | bus.i_en[j];
      for (int i = 0; i < N_PORTS; i++) arb_req[j][i] = dec[i][j];
    end
  end

  for (genvar j = 0; j < M_PORTS; j++) begin : g_arb
    ant_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (arb_req[j]),
      .en    (free[j]),
      .grant (arb_gnt[j])
    );
  end

  always_comb begin
    gnt_any  = '0;
    won      = '0;
    sel_data = '{default: '0};
    for (int j = 0; j < M_PORTS; j++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (arb_gnt[j][i]) begin
          won[j]      = 1'b1;
          sel_data[j] = bus.i_data[i];
          gnt_any[i]  = 1'b1;
        end
      end
    end
    bus.o_grant = reset ? '0 : gnt_any;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.o_data     <= '0;
      bus.o_data_val <= '0;
      bus.o_error    <= 1'b0;
    end else begin
      if (malformed) bus.o_error <= 1'b1;
      for (int j = 0; j < M_PORTS; j++) begin
        if (free[j]) begin
          bus.o_data_val[j] <= won[j];
          if (won[j]) bus.o_data[j] <= sel_data[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_ant_switch_allocator.sv
// Scoreboard bench for the switch allocator: a queue-based reference model predicts
// grants and output packets; a separate monitor pops and compares on every output transfer.
module tb_ant_switch_allocator;
  import ant_switch_allocator_pkg::*;

  localparam int NP = N;
  localparam int MP = M;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ant_switch_allocator_if #(.N_PORTS(NP), .M_PORTS(MP)) bus ();

  ant_switch_allocator #(.N_PORTS(NP), .M_PORTS(MP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  packet_t exp_q [MP][$];
  int      mptr   [MP];
  bit      mvalid [MP];
  bit      mfree  [MP];
  int      mwin   [MP];
  packet_t wdata  [MP];
  bit      mgrant [NP];
  bit      merr, merr_pend;

  logic [0:NP-1] g_snap;
  logic [0:MP-1] v_snap;
  logic          e_snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:NP-1] oh_in(input int i);
    logic [0:NP-1] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:MP-1] oh_out(input int j);
    logic [0:MP-1] v;
    v = '0;
    v[j] = 1'b1;
    return v;
  endfunction

  function automatic int lowest_bit(input logic [MP-1:0] r);
    for (int j = 0; j < MP; j++) if (r[j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < MP; j++) begin
      mptr[j]   = 0;
      mvalid[j] = 1'b0;
      exp_q[j].delete();
    end
    for (int i = 0; i < NP; i++) mgrant[i] = 1'b0;
    merr      = 1'b0;
    merr_pend = 1'b0;
  endtask

  // Decide this cycle's winners from the rules, compare against the DUT
  task automatic model_eval();
    int            want [NP];
    logic [0:NP-1] eg;
    logic [0:MP-1] ev;
    merr_pend = 1'b0;
    for (int i = 0; i < NP; i++) begin
      mgrant[i] = 1'b0;
      want[i]   = -1;
      if (bus.i_data_val[i]) begin
        if ($countones(bus.i_output_req[i]) != 1) merr_pend = 1'b1;
        want[i] = lowest_bit(bus.i_output_req[i]);
      end
    end
    for (int j = 0; j < MP; j++) begin
      mfree[j] = !mvalid[j] || bus.i_en[j];
      mwin[j]  = -1;
      if (mfree[j]) begin
        for (int k = 0; k < NP; k++) begin
          int i;
          i = (mptr[j] + k) % NP;
          if (mwin[j] < 0 && want[i] == j) mwin[j] = i;
        end
      end
      if (mwin[j] >= 0) begin
        mgrant[mwin[j]] = 1'b1;
        wdata[j]        = bus.i_data[mwin[j]];
      end
    end
    eg = '0;
    ev = '0;
    for (int i = 0; i < NP; i++) eg[i] = mgrant[i];
    for (int j = 0; j < MP; j++) ev[j] = mvalid[j];
    g_snap = bus.o_grant;
    v_snap = bus.o_data_val;
    e_snap = bus.o_error;
    chk("grant", g_snap, eg);
    chk("out_valid", v_snap, ev);
    chk("error", e_snap, merr);
  endtask

  task automatic model_commit();
    for (int j = 0; j < MP; j++) begin
      if (mfree[j]) begin
        if (mwin[j] >= 0) begin
          mvalid[j] = 1'b1;
          exp_q[j].push_back(wdata[j]);
          mptr[j] = (mwin[j] + 1) % NP;
        end else begin
          mvalid[j] = 1'b0;
        end
      end
    end
    merr = merr | merr_pend;
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_data       = '0;
    bus.i_data_val   = '0;
    bus.i_output_req = '0;
  endtask

  task automatic drive(input int i, input logic [MP-1:0] req);
    bus.i_data_val[i]   = 1'b1;
    bus.i_output_req[i] = req;
    bus.i_data[i]       = packet_t'($urandom);
  endtask

  // Monitor: every handshake on an output must deliver the oldest predicted packet
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int j = 0; j < MP; j++) begin
          if (bus.o_data_val[j] && bus.i_en[j]) begin
            if (exp_q[j].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL out%0d_unexpected: got %0h expected no packet", j, bus.o_data[j]);
            end else begin
              chk($sformatf("out%0d_data", j), bus.o_data[j], exp_q[j].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    int      order [4];
    packet_t pkt_a;
    logic [MP-1:0] r;
    order = '{1, 3, 4, 1};

    clear_inputs();
    bus.i_en = '1;
    model_reset();
    drive(0, 5'b00001);
    drive(3, 5'b00100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_valid", bus.o_data_val, 0);
    chk("rst_error", bus.o_error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_inputs();

    // Contention on the local output from reset
    drive(1, 5'b10000);
    drive(3, 5'b10000);
    drive(4, 5'b10000);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("contention_order", g_snap, oh_in(order[c]));
      bus.i_data[order[c]] = packet_t'($urandom);
    end
    clear_inputs();
    tick();

    // Single packet
    drive(0, 5'b00100);
    tick();
    chk("single_grant", g_snap, oh_in(0));
    clear_inputs();
    tick();
    chk("single_valid", v_snap, oh_out(EAST));

    // Backpressure on north
    drive(1, 5'b01000);
    pkt_a = bus.i_data[1];
    tick();
    clear_inputs();
    bus.i_en[NORTH] = 1'b0;
    drive(2, 5'b01000);
    repeat (3) begin
      tick();
      chk("bp_no_grant", g_snap[2], 0);
      chk("bp_hold_valid", v_snap[NORTH], 1);
      chk("bp_hold_data", bus.o_data[NORTH], pkt_a);
    end
    bus.i_en[NORTH] = 1'b1;
    tick();
    chk("bp_release_grant", g_snap[2], 1);
    clear_inputs();
    tick();
    chk("bp_no_bubble", v_snap[NORTH], 1);

    // All inputs to distinct outputs
    drive(0, 5'b00100);
    drive(1, 5'b01000);
    drive(2, 5'b00001);
    drive(3, 5'b00010);
    drive(4, 5'b10000);
    tick();
    chk("parallel_grant", g_snap, 5'b11111);
    clear_inputs();
    tick();
    chk("parallel_valid", v_snap, 5'b11111);

    // Malformed requests
    drive(2, 5'b01100);
    tick();
    chk("err_multi_grant", g_snap, oh_in(2));
    clear_inputs();
    tick();
    chk("err_multi_flag", e_snap, 1);
    chk("err_multi_route", v_snap, oh_out(EAST));
    drive(2, 5'b00000);
    repeat (3) begin
      tick();
      chk("err_zero_no_grant", g_snap[2], 0);
      chk("err_sticky", e_snap, 1);
    end
    clear_inputs();

    // Reset in the middle of traffic
    drive(2, 5'b00001);
    drive(0, 5'b00100);
    drive(1, 5'b10000);
    tick();
    clear_inputs();
    bus.i_en[WEST] = 1'b0;
    bus.i_en[EAST] = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.o_data_val, 0);
    chk("mid_rst_error", bus.o_error, 0);
    chk("mid_rst_grant", bus.o_grant, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.i_en = '1;
    drive(3, 5'b10000);
    drive(1, 5'b10000);
    tick();
    chk("post_rst_lowest", g_snap, oh_in(1));
    clear_inputs();
    tick();

    // Randomized traffic; ungranted inputs keep their packet and request stable
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!bus.i_data_val[i] || mgrant[i]) begin
          if ($urandom_range(9) < 6) begin
            r = '0;
            r[$urandom_range(MP-1)] = 1'b1;
            drive(i, r);
          end else begin
            bus.i_data_val[i]   = 1'b0;
            bus.i_output_req[i] = '0;
          end
        end
      end
      for (int j = 0; j < MP; j++) bus.i_en[j] = ($urandom_range(9) < 7);
      tick();
    end

    clear_inputs();
    bus.i_en = '1;
    repeat (3) tick();
    for (int j = 0; j < MP; j++) chk($sformatf("drain_out%0d", j), exp_q[j].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ant_switch_allocator.md
Name: ant_switch_allocator

Overview:
- Downstream stage of the ant routing agent inside each router.
- Consumes per-input packets plus one-hot output requests, arbitrates every output port round-robin among the inputs requesting it, and drives a registered crossbar output with a valid/ready handshake per output.
- Normal, forward-ant and backward-ant packets are treated identically; packet contents pass through unmodified.

Parameters:
- N_PORTS, default `N, number of input ports; index 4 is the local port.
- M_PORTS, default `M, number of output ports. Request bit j selects output j: 0=west(x-1), 1=south(y-1), 2=east(x+1), 3=north(y+1), 4=local.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_data  input  packet_t[0:N_PORTS-1]  packet on each input
- i_data_val  input  [0:N_PORTS-1]  input packet valid
- i_output_req  input  [0:N_PORTS-1][M_PORTS-1:0]  one-hot output request per input
- i_en  input  [0:M_PORTS-1]  downstream ready per output
- o_data  output  packet_t[0:M_PORTS-1]  registered packet per output
- o_data_val  output  [0:M_PORTS-1]  output packet valid
- o_grant  output  [0:N_PORTS-1]  combinational; input packet taken this cycle, upstream pops
- o_error  output  1  sticky malformed-request flag

Behaviour:
- Reset (asynchronous, active-high): o_data='0, o_data_val='0, o_error=0, all round-robin pointers=0. o_grant is combinational and is '0 while reset is high.
- Effective request of input i to output j: i_data_val[i] & i_output_req[i][j].
- Output j may accept a packet when it is free: !o_data_val[j] | i_en[j].
- Output transfer completes on a clock edge where o_data_val[j] & i_en[j].

Arbitration:
- Per output j: among requesting inputs, the winner is the first index at or after ptr[j], searched in increasing order with wrap from N_PORTS-1 to 0.
- No winner is chosen when output j is not free.

Grant and register update:
- o_grant[i]=1 in the same cycle that input i wins any output.
- On that edge: o_data[j]<=i_data[winner], o_data_val[j]<=1, ptr[j]<=(winner+1) mod N_PORTS.
- Output free, no winner: o_data_val[j]<=0 on the edge; o_data[j] holds its value.
- Output not free (valid and !i_en): o_data and o_data_val hold, ptr[j] holds.
- A pointer changes only on a grant.

Latency and throughput:
- 1 cycle from an input granted to o_data_val.
- Full throughput of one packet per output per cycle while i_en is high.

Request decode and errors:
- Each input can win at most one output: the lowest set bit of its request is used.
- More than one bit set with valid high: decode uses the lowest set bit, and o_error<=1.
- Valid with a zero request: the input is never granted, and o_error<=1.
- o_error clears only on reset.

Other rules:
- Input without a grant: upstream must hold its packet and request stable; the allocator keeps no input state.
- Simultaneous transfer and new grant on the same output in one edge is legal (back-to-back).
- Reset mid-operation drops any held output packets; no partial state survives.

Decomposition:
- packet_t, `N, `M, `X_NODES and `Y_NODES stay in config.sv.
- Add a localparam set for output indices (WEST=0, SOUTH=1, EAST=2, NORTH=3, LOCAL=4) in config.sv.
- Sub-module ant_rr_arbiter, instantiated M_PORTS times:
  - inputs: request vector, enable.
  - output: one-hot grant.
  - state: internal pointer with the update rule above.
  - clk/reset identical to the parent.
- Top level holds request decode, grant OR-reduction, output registers and o_error.

Test Plan:
- Single packet: input 0 valid, req=5'b00100, i_en[2]=1 → o_grant[0]=1 in the same cycle; next cycle o_data_val[2]=1, o_data[2]=input packet; all other outputs invalid.
- Contention: inputs 1, 3 and 4 request output 4 continuously with i_en[4]=1 from reset → grants in order 1, 3, 4, 1, one per cycle; each packet appears on o_data[4] one cycle later.
- Backpressure: output 3 holds packet A, i_en[3]=0 for 3 cycles while input 2 requests output 3 → o_data[3]=A stable and o_grant[2]=0 for 3 cycles. Raise i_en[3] → o_grant[2]=1 that cycle; packet B appears on the next cycle with no bubble.
- Parallel: inputs 0–4 request outputs 2, 3, 0, 1, 4 respectively → all five o_grant high in one cycle; all five outputs valid the next cycle.
- Error: input 2 valid with req=5'b01100 → granted to output 2, o_error=1 and stays 1. Input 2 valid with req=0 → never granted, o_error=1.
- Reset mid-operation: outputs 0 and 2 valid, pointers non-zero, assert reset between edges → o_data_val='0 and o_error=0 immediately. After release, first contention on output 4 grants the lowest requesting index.
